// File: rtl/ac_pkg.sv
// rtl/ac_pkg.sv - shared types and constants for the ac_ext accumulator
package ac_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_INC   = 3'd1,
        OP_DEC   = 3'd2,
        OP_CLR   = 3'd3,
        OP_SHIFT = 3'd4,
        OP_ALU   = 3'd5,
        OP_LOAD  = 3'd6
    } op_t;

    // Fixed-priority resolution of the control-unit strobes; only the winner acts.
    function automatic op_t op_select(
        input logic inc,
        input logic dec,
        input logic clr,
        input logic sh,
        input logic alu,
        input logic wr
    );
        if (inc)      return OP_INC;
        else if (dec) return OP_DEC;
        else if (clr) return OP_CLR;
        else if (sh)  return OP_SHIFT;
        else if (alu) return OP_ALU;
        else if (wr)  return OP_LOAD;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/ac_shift_ctrl.sv
// rtl/ac_shift_ctrl.sv - one-bit-per-clock shift sequencer with busy/done handshake
module ac_shift_ctrl
    import ac_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [SH_W-1:0] i_amt,
    input  logic            i_dir,
    input  logic            i_arith,
    input  logic            i_abort,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_step,
    output logic            o_dir,
    output logic            o_arith
);

    localparam logic [SH_W-1:0] AMT_MAX = SH_W'(DATA_W - 1);
    localparam logic [SH_W-1:0] CNT_ONE = SH_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SH_W-1:0] r_cnt;
    logic [SH_W-1:0] w_cnt_nxt;
    logic [SH_W-1:0] w_amt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_dir;
    logic            r_arith;
    logic            w_latch;
    logic            w_step;

    // Out-of-range amounts are clamped rather than rejected.
    assign w_amt = (i_amt > AMT_MAX) ? AMT_MAX : i_amt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    if (w_amt == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = w_amt;
                        w_latch     = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (i_abort) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_step    = 1'b1;
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_dir   <= SH_LEFT;
            r_arith <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_dir   <= i_dir;
                r_arith <= i_arith;
            end
        end
    end

    assign o_busy  = (r_state == SHIFT);
    assign o_done  = r_done;
    assign o_step  = w_step;
    assign o_dir   = r_dir;
    assign o_arith = r_arith;

endmodule

// File: rtl/ac_ext.sv
// rtl/ac_ext.sv - parametrised accumulator with inc/dec, flags and serial shifter
module ac_ext
    import ac_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int BUS_W  = 17,
    parameter int SAT_EN = 0,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [BUS_W-1:0]  datain,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_to_ac,
    input  logic              inc_en,
    input  logic              dec_en,
    input  logic              clr_en,
    input  logic              shift_start,
    input  logic [SH_W-1:0]   shift_amt,
    input  logic              shift_dir,
    input  logic              shift_arith,
    output logic [DATA_W-1:0] dataout,
    output logic              zero,
    output logic              ovf,
    output logic              shift_out,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    logic [DATA_W-1:0] r_acc;
    logic              r_ovf;
    logic              r_shift_out;
    op_t               w_op;
    logic              w_busy;
    logic              w_done;
    logic              w_step;
    logic              w_sh_dir;
    logic              w_sh_arith;
    logic [DATA_W-1:0] w_shifted;
    logic              w_shifted_bit;
    logic              w_unused_bus;

    // Only the low DATA_W bus bits are loaded; the rest are deliberately ignored.
    assign w_unused_bus = ^{1'b0, datain};

    assign w_op = op_select(inc_en, dec_en, clr_en, shift_start, alu_to_ac, write_en);

    ac_shift_ctrl #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_shift_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_op == OP_SHIFT),
        .i_amt   (shift_amt),
        .i_dir   (shift_dir),
        .i_arith (shift_arith),
        .i_abort (clr_en),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_step  (w_step),
        .o_dir   (w_sh_dir),
        .o_arith (w_sh_arith)
    );

    always_comb begin
        w_shifted     = r_acc;
        w_shifted_bit = r_shift_out;
        if (w_sh_dir == SH_LEFT) begin
            w_shifted     = {r_acc[DATA_W-2:0], 1'b0};
            w_shifted_bit = r_acc[DATA_W-1];
        end else begin
            w_shifted     = {w_sh_arith & r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
            w_shifted_bit = r_acc[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= ZERO;
            r_ovf       <= 1'b0;
            r_shift_out <= 1'b0;
        end else if (w_busy) begin
            // While shifting, clear is the only op honoured; it aborts the shift.
            if (clr_en) begin
                r_acc <= ZERO;
                r_ovf <= 1'b0;
            end else if (w_step) begin
                r_acc       <= w_shifted;
                r_shift_out <= w_shifted_bit;
            end
        end else begin
            case (w_op)
                OP_INC: begin
                    if (r_acc == ALL_ONES) begin
                        r_acc <= (SAT_EN != 0) ? ALL_ONES : ZERO;
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc <= r_acc + ONE;
                    end
                end
                OP_DEC: begin
                    if (r_acc == ZERO) begin
                        r_acc <= (SAT_EN != 0) ? ZERO : ALL_ONES;
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc <= r_acc - ONE;
                    end
                end
                OP_CLR: begin
                    r_acc <= ZERO;
                    r_ovf <= 1'b0;
                end
                OP_ALU: begin
                    r_acc <= alu_out;
                    r_ovf <= 1'b0;
                end
                OP_LOAD: begin
                    r_acc <= datain[DATA_W-1:0];
                    r_ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dataout   = r_acc;
    assign zero      = (r_acc == ZERO);
    assign ovf       = r_ovf;
    assign shift_out = r_shift_out;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule

// File: tb/tb_ac_ext.sv
// tb/tb_ac_ext.sv - self-checking bench for ac_ext (wrapping and saturating builds)
module tb_ac_ext;

    localparam int W = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_en, alu_to_ac, inc_en, dec_en, clr_en;
    logic        shift_start, shift_dir, shift_arith;
    logic [16:0] datain;
    logic [11:0] alu_out;
    logic [3:0]  shift_amt;

    logic [11:0] dout [2];
    logic        zero [2];
    logic        ovf  [2];
    logic        sho  [2];
    logic        busy [2];
    logic        done [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ac_ext #(.DATA_W(12), .BUS_W(17), .SAT_EN(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .datain(datain),
        .alu_out(alu_out), .alu_to_ac(alu_to_ac), .inc_en(inc_en), .dec_en(dec_en),
        .clr_en(clr_en), .shift_start(shift_start), .shift_amt(shift_amt),
        .shift_dir(shift_dir), .shift_arith(shift_arith), .dataout(dout[0]),
        .zero(zero[0]), .ovf(ovf[0]), .shift_out(sho[0]), .busy(busy[0]), .done(done[0])
    );

    ac_ext #(.DATA_W(12), .BUS_W(17), .SAT_EN(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .datain(datain),
        .alu_out(alu_out), .alu_to_ac(alu_to_ac), .inc_en(inc_en), .dec_en(dec_en),
        .clr_en(clr_en), .shift_start(shift_start), .shift_amt(shift_amt),
        .shift_dir(shift_dir), .shift_arith(shift_arith), .dataout(dout[1]),
        .zero(zero[1]), .ovf(ovf[1]), .shift_out(sho[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a shift is tracked as (original value, amount, steps taken)
    // and the visible value is the original shifted by the step count.
    logic [11:0] m_acc [2];
    logic [11:0] m_v0  [2];
    bit          m_ovf [2], m_so [2], m_busy [2], m_done [2], m_dir [2], m_ar [2];
    int          m_n   [2], m_k  [2];
    bit          m_valid = 0;

    function automatic logic [11:0] shf(input logic [11:0] v, input int k, input bit dir, input bit ar);
        logic signed [11:0] s;
        if (!dir) return v << k;
        if (ar) begin
            s = $signed(v) >>> k;
            return s;
        end
        return v >> k;
    endfunction

    task automatic model_step(input int i, input bit sat);
        int amt;
        m_done[i] = 0;
        if (!rst_n) begin
            m_acc[i] = 0; m_ovf[i] = 0; m_so[i] = 0; m_busy[i] = 0;
        end else if (m_busy[i]) begin
            if (clr_en) begin
                m_acc[i] = 0; m_ovf[i] = 0; m_busy[i] = 0;
            end else begin
                m_k[i]++;
                m_acc[i] = shf(m_v0[i], m_k[i], m_dir[i], m_ar[i]);
                m_so[i]  = m_dir[i] ? m_v0[i][m_k[i]-1] : m_v0[i][W-m_k[i]];
                if (m_k[i] == m_n[i]) begin
                    m_busy[i] = 0; m_done[i] = 1;
                end
            end
        end else if (inc_en) begin
            if (m_acc[i] == 12'hFFF) begin
                m_acc[i] = sat ? 12'hFFF : 12'h000; m_ovf[i] = 1;
            end else m_acc[i] = m_acc[i] + 1;
        end else if (dec_en) begin
            if (m_acc[i] == 12'h000) begin
                m_acc[i] = sat ? 12'h000 : 12'hFFF; m_ovf[i] = 1;
            end else m_acc[i] = m_acc[i] - 1;
        end else if (clr_en) begin
            m_acc[i] = 0; m_ovf[i] = 0;
        end else if (shift_start) begin
            amt = (int'(shift_amt) > W - 1) ? W - 1 : int'(shift_amt);
            if (amt == 0) m_done[i] = 1;
            else begin
                m_busy[i] = 1; m_n[i] = amt; m_k[i] = 0; m_v0[i] = m_acc[i];
                m_dir[i] = shift_dir; m_ar[i] = shift_arith;
            end
        end else if (alu_to_ac) begin
            m_acc[i] = alu_out; m_ovf[i] = 0;
        end else if (write_en) begin
            m_acc[i] = datain[11:0]; m_ovf[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 0);
        model_step(1, 1);
        if (!rst_n) m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("m%0d_dataout", i), 32'(dout[i]), 32'(m_acc[i]));
                check($sformatf("m%0d_zero", i), 32'(zero[i]), 32'(m_acc[i] == 12'h000));
                check($sformatf("m%0d_ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
                check($sformatf("m%0d_shift_out", i), 32'(sho[i]), 32'(m_so[i]));
                check($sformatf("m%0d_busy", i), 32'(busy[i]), 32'(m_busy[i]));
                check($sformatf("m%0d_done", i), 32'(done[i]), 32'(m_done[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        write_en = 0; alu_to_ac = 0; inc_en = 0; dec_en = 0; clr_en = 0;
        shift_start = 0; shift_dir = 0; shift_arith = 0; shift_amt = 0;
    endtask

    task automatic wr(input logic [16:0] v);
        write_en = 1; datain = v;
        tick();
        write_en = 0;
    endtask

    task automatic shift(input logic [3:0] a, input bit dir, input bit ar);
        shift_start = 1; shift_amt = a; shift_dir = dir; shift_arith = ar;
        tick();
        clear_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        datain = '0; alu_out = '0; rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        check("rst_dataout", 32'(dout[0]), 32'h000);
        check("rst_zero", 32'(zero[0]), 32'h1);
        check("rst_busy", 32'(busy[0]), 32'h0);

        wr(17'h1_0ABC);
        check("load_abc", 32'(dout[0]), 32'hABC);
        check("load_zero", 32'(zero[0]), 32'h0);

        wr(17'h0_0FFF);
        inc_en = 1; tick(); inc_en = 0;
        check("wrap_data", 32'(dout[0]), 32'h000);
        check("wrap_zero", 32'(zero[0]), 32'h1);
        check("wrap_ovf", 32'(ovf[0]), 32'h1);
        check("sat_data", 32'(dout[1]), 32'hFFF);
        check("sat_ovf", 32'(ovf[1]), 32'h1);
        wr(17'h0_0005);
        check("ovf_clr_wrap", 32'(ovf[0]), 32'h0);
        check("ovf_clr_sat", 32'(ovf[1]), 32'h0);

        inc_en = 1; clr_en = 1; alu_to_ac = 1; alu_out = 12'h123;
        tick(); clear_in();
        check("prio_inc", 32'(dout[0]), 32'h006);
        clr_en = 1; alu_to_ac = 1;
        tick(); clear_in();
        check("prio_clr", 32'(dout[0]), 32'h000);

        wr(17'h0_0804);
        shift(4'd3, 1, 1);
        check("asr_busy0", 32'(busy[0]), 32'h1);
        check("asr_hold", 32'(dout[0]), 32'h804);
        tick(); tick();
        check("asr_step2", 32'(dout[0]), 32'hE01);
        tick();
        check("asr_data", 32'(dout[0]), 32'hF00);
        check("asr_so", 32'(sho[0]), 32'h1);
        check("asr_done", 32'(done[0]), 32'h1);
        check("asr_idle", 32'(busy[0]), 32'h0);
        tick();
        check("asr_done_pulse", 32'(done[0]), 32'h0);

        wr(17'h0_0801);
        shift(4'd1, 0, 0);
        tick();
        check("shl_data", 32'(dout[0]), 32'h002);
        check("shl_so", 32'(sho[0]), 32'h1);
        check("shl_done", 32'(done[0]), 32'h1);
        inc_en = 1; tick(); inc_en = 0;
        check("done_cycle_inc", 32'(dout[0]), 32'h003);

        wr(17'h0_03C5);
        shift(4'd0, 0, 0);
        check("amt0_done", 32'(done[0]), 32'h1);
        check("amt0_busy", 32'(busy[0]), 32'h0);
        check("amt0_data", 32'(dout[0]), 32'h3C5);
        tick();

        wr(17'h0_000F);
        shift(4'd4, 0, 0);
        write_en = 1; datain = 17'h0_0777; tick(); write_en = 0;
        inc_en = 1; tick(); inc_en = 0;
        tick(); tick();
        check("ign_data", 32'(dout[0]), 32'h0F0);
        check("ign_done", 32'(done[0]), 32'h1);

        wr(17'h0_0ABC);
        shift(4'd5, 1, 0);
        tick();
        clr_en = 1; tick(); clr_en = 0;
        check("abort_data", 32'(dout[0]), 32'h000);
        check("abort_busy", 32'(busy[0]), 32'h0);
        tick();
        check("abort_no_done", 32'(done[0]), 32'h0);

        wr(17'h0_0ABC);
        shift(4'd5, 1, 0);
        tick();
        rst_n = 0; tick(); rst_n = 1;
        check("rstab_data", 32'(dout[0]), 32'h000);
        check("rstab_zero", 32'(zero[0]), 32'h1);
        check("rstab_busy", 32'(busy[0]), 32'h0);
        check("rstab_so", 32'(sho[0]), 32'h0);
        tick();
        check("rstab_no_done", 32'(done[0]), 32'h0);

        wr(17'h0_0001);
        shift(4'd15, 0, 0);
        repeat (10) tick();
        check("clamp_busy", 32'(busy[0]), 32'h1);
        tick();
        check("clamp_data", 32'(dout[0]), 32'h800);
        check("clamp_done", 32'(done[0]), 32'h1);

        wr(17'h0_0000);
        dec_en = 1; tick(); dec_en = 0;
        check("decw_data", 32'(dout[0]), 32'hFFF);
        check("decw_ovf", 32'(ovf[0]), 32'h1);
        check("decs_data", 32'(dout[1]), 32'h000);
        check("decs_ovf", 32'(ovf[1]), 32'h1);

        wr(17'h0_0010);
        dec_en = 1; tick(); dec_en = 0;
        check("dec_data", 32'(dout[0]), 32'h00F);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ac_ext.md
Name: ac_ext

Overview:
Parametrised accumulator for the processor datapath, and the next generation of the 12-bit AC register. Supports generic data/bus widths, load from bus, ALU write-back, clear, increment and decrement (wrapping or saturating), status flags, and a multi-cycle shifter that moves one bit per clock with a busy/done handshake. Sits between the shared bus, the ALU and the control unit. The control unit drives one-hot-ish op strobes; multiple strobes are resolved by fixed priority.

Parameters:
DATA_W, 12, accumulator width in bits (>=2)
BUS_W, 17, bus width; BUS_W >= DATA_W; load takes datain[DATA_W-1:0]
SAT_EN, 0, 1 = inc/dec saturate instead of wrapping
SH_W, $clog2(DATA_W), width of shift amount (derived; not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
write_en  in  1  load dataout from datain[DATA_W-1:0]
datain  in  BUS_W  bus data
alu_out  in  DATA_W  ALU result
alu_to_ac  in  1  load dataout from alu_out
inc_en  in  1  dataout + 1
dec_en  in  1  dataout - 1
clr_en  in  1  dataout <= 0; also aborts a shift
shift_start  in  1  start shift of shift_amt bits
shift_amt  in  SH_W  number of bit positions, 0..DATA_W-1
shift_dir  in  1  0 = left, 1 = right
shift_arith  in  1  right shifts replicate MSB when 1; ignored for left
dataout  out  DATA_W  accumulator value to bus/ALU
zero  out  1  combinational, dataout == 0
ovf  out  1  sticky inc/dec wrap/saturate flag
shift_out  out  1  last bit shifted out
busy  out  1  shift in progress
done  out  1  one-cycle pulse at shift completion

Behaviour:
- Reset (rst_n=0 at edge): dataout=0, ovf=0, shift_out=0, busy=0, done=0, FSM=IDLE, counter=0. zero reads 1. Reset mid-shift abandons the shift; no done is issued.
- FSM states: IDLE, SHIFT. busy = (state==SHIFT). done is registered and defaults to 0 every cycle.
- IDLE priority, highest first: inc_en, dec_en, clr_en, shift_start, alu_to_ac, write_en. Only the winner acts; all others are dropped, including shift_start.
- inc: wraps all-ones->0 (SAT_EN=0) or holds all-ones (SAT_EN=1); sets ovf in both cases. dec: symmetric at 0.
- clr_en, alu_to_ac and write_en clear ovf. shift does not affect ovf.
- All single-cycle ops take effect at the sampling edge (1-cycle latency).
- shift_start in IDLE with amt=0: dataout is unchanged, shift_out is unchanged, done=1 after the same edge, and the FSM stays IDLE.
- shift_start in IDLE with amt=N>0: the edge latches cnt=N, dir and arith, and enters SHIFT. dataout is not yet modified.
- In SHIFT, each edge shifts one bit:
  - left: fill 0; shift_out = old MSB.
  - right: fill 0, or old MSB if arith; shift_out = old LSB.
  - cnt decrements. At the edge where cnt==1, the last shift is performed, the FSM goes to IDLE and done=1.
  - Result: busy is high for exactly N cycles, and done is high for the one cycle after busy falls.
- While busy: inc/dec/alu/write/shift_start are ignored (not queued). clr_en aborts: dataout=0, ovf=0, FSM=IDLE, done stays 0.
- In the done cycle the FSM is IDLE, so ops are accepted normally.
- shift_amt >= DATA_W is illegal; the design clamps it to DATA_W-1.

Decomposition:
- Package ac_pkg holds:
  - state enum {IDLE, SHIFT};
  - constants SH_LEFT=0 and SH_RIGHT=1;
  - an op-select enum for the priority encoder.
- Sub-module ac_shift_ctrl holds the FSM, down-counter, busy/done and the latched dir/arith. It outputs a per-cycle shift-step strobe. The datapath (register, inc/dec/sat, flags) stays in ac_ext.

Test Plan:
- Reset then write_en, datain=17'h1_0ABC (DATA_W=12) -> dataout=12'hABC next cycle, zero=0, ovf=0.
- Wrap: load 12'hFFF, inc_en -> dataout=0, zero=1, ovf=1. With SAT_EN=1 -> dataout=12'hFFF, ovf=1. Then write_en -> ovf=0.
- Priority: inc_en+clr_en+alu_to_ac together with dataout=5 -> dataout=6. clr_en+alu_to_ac -> dataout=0.
- Arithmetic right shift: load 12'h804, shift_amt=3, dir=1, arith=1 -> busy high 3 cycles, then done pulses 1 cycle, dataout=12'hF00, shift_out=1. Left shift of 12'h801 by 1 -> 12'h002, shift_out=1.
- Shift edge cases: amt=0 -> done next cycle, busy never high, dataout unchanged. write_en/inc_en during busy -> ignored, final result unaffected.
- Abort: clr_en at busy cycle 2 of a 5-bit shift -> dataout=0, busy=0 next cycle, no done. Same scenario with rst_n=0 instead -> all outputs at reset values.
